// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The MULDIV_DIV_EN macro (see muldiv_unit) controls whether the divider is built.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_e;

  localparam int MULDIV_ITER    = 32;
  localparam int MULDIV_LATENCY = 34;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Whether Rus1 / Rus2 are interpreted as two's complement for this opcode.
  function automatic logic op_a_signed(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two-lane conditional two's-complement negation: magnitude extraction on the
// operand side, sign restoration on the result side.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a_i,
  input  logic          a_neg_i,
  input  logic [WB-1:0] b_i,
  input  logic          b_neg_i,
  output logic [WA-1:0] a_o,
  output logic [WB-1:0] b_o
);

  assign a_o = a_neg_i ? -a_i : a_i;
  assign b_o = b_neg_i ? -b_i : b_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on magnitudes, then one fix cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise opcodes 4-7 return 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Rus1,
  input  logic [XLEN-1:0] Rus2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic [31:0]   amag_q, amag_d, bmag_q, bmag_d;
  logic [63:0]   prod_q, prod_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [31:0]   result_q, result_d;

  logic [31:0]   in_amag, in_bmag, out_rem, fix_result, rem_val;
  logic [63:0]   out_prod;
  logic [32:0]   mul_sum;
  muldiv_op_e    in_op;

`ifdef MULDIV_DIV_EN
  logic [31:0]   rem_q, rem_d, a_q, a_d;
  logic [32:0]   div_shift, div_sub;
  logic          div_ge, div_zero, div_ovf;
  assign rem_val = rem_q;
`else
  assign rem_val = '0;
`endif

  assign in_op = muldiv_op_e'(Funct3);

  muldiv_sign_fix #(.WA(32), .WB(32)) u_in_fix (
    .a_i     (Rus1),
    .a_neg_i (op_a_signed(in_op) & Rus1[31]),
    .b_i     (Rus2),
    .b_neg_i (op_b_signed(in_op) & Rus2[31]),
    .a_o     (in_amag),
    .b_o     (in_bmag)
  );

  // Lane A carries the product, or the quotient in its low half; lane B the remainder.
  muldiv_sign_fix #(.WA(64), .WB(32)) u_out_fix (
    .a_i     (prod_q),
    .a_neg_i (a_sign_q ^ b_sign_q),
    .b_i     (rem_val),
    .b_neg_i (a_sign_q),
    .a_o     (out_prod),
    .b_o     (out_rem)
  );

  assign mul_sum = {1'b0, prod_q[63:32]} + {1'b0, amag_q};

`ifdef MULDIV_DIV_EN
  assign div_shift = {rem_q, prod_q[31]};
  assign div_ge    = div_shift >= {1'b0, bmag_q};
  assign div_sub   = div_shift - {1'b0, bmag_q};
  assign div_zero  = bmag_q == '0;
  assign div_ovf   = a_sign_q && b_sign_q && amag_q == INT_MIN && bmag_q == 32'd1;
`endif

  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL:                        fix_result = out_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = out_prod[63:32];
      default: begin
`ifdef MULDIV_DIV_EN
        if (op_q inside {OP_REM, OP_REMU})
          fix_result = div_zero ? a_q : (div_ovf ? 32'd0 : out_rem);
        else
          fix_result = div_zero ? DIV_ZERO_Q : (div_ovf ? INT_MIN : out_prod[31:0]);
`else
        fix_result = out_rem;
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    rem_d    = rem_q;
    a_d      = a_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = CALC;
          op_d     = in_op;
          cnt_d    = '0;
          a_sign_d = op_a_signed(in_op) & Rus1[31];
          b_sign_d = op_b_signed(in_op) & Rus2[31];
          amag_d   = in_amag;
          bmag_d   = in_bmag;
          // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
          prod_d   = {32'd0, Funct3[2] ? in_amag : in_bmag};
          busy_d   = 1'b1;
`ifdef MULDIV_DIV_EN
          rem_d    = '0;
          a_d      = Rus1;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MULDIV_ITER - 1))
          state_d = FIX;
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
          rem_d  = div_ge ? 32'(div_sub) : 32'(div_shift);
          prod_d = {prod_q[63:32], prod_q[30:0], div_ge};
        end else
`endif
        prod_d = prod_q[0] ? {mul_sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};
      end
      FIX: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = fix_result;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      amag_q   <= '0;
      bmag_q   <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIV_EN
      rem_q    <= '0;
      a_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef MULDIV_DIV_EN
      rem_q    <= rem_d;
      a_q      <= a_d;
`endif
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
